// File: rtl/alu_req_arbiter.sv
// Round-robin arbiter that shares one ALU between two requesters.
// Runs one operation at a time with a timeout on the ALU's valid flag.
module alu_req_arbiter #(
   parameter int OP_WIDTH  = 8,
   parameter int OUT_WIDTH = 16,
   parameter int FUN_WIDTH = 4,
   parameter int TIMEOUT   = 8
) (
   input  logic                 CLK,
   input  logic                 RST,
   input  logic                 req0_valid,
   output logic                 req0_ready,
   input  logic [OP_WIDTH-1:0]  req0_a,
   input  logic [OP_WIDTH-1:0]  req0_b,
   input  logic [FUN_WIDTH-1:0] req0_fun,
   input  logic                 req1_valid,
   output logic                 req1_ready,
   input  logic [OP_WIDTH-1:0]  req1_a,
   input  logic [OP_WIDTH-1:0]  req1_b,
   input  logic [FUN_WIDTH-1:0] req1_fun,
   output logic                 resp0_valid,
   output logic                 resp1_valid,
   output logic                 resp_err,
   output logic [OUT_WIDTH-1:0] resp_data,
   output logic [OP_WIDTH-1:0]  alu_a,
   output logic [OP_WIDTH-1:0]  alu_b,
   output logic [FUN_WIDTH-1:0] alu_fun,
   output logic                 alu_en,
   input  logic [OUT_WIDTH-1:0] alu_out,
   input  logic                 alu_out_valid,
   output logic                 busy
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

   // The last WAIT cycle is the TIMEOUT-th one; the counter starts at 0.
   localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

   state_t     state;
   logic       last_grant;
   logic       grant;
   logic [7:0] wait_cnt;
   logic       win1;
   logic       take;

   always_comb begin
      win1 = 1'b0;
      if (req0_valid && req1_valid) begin
         win1 = ~last_grant;
      end else begin
         win1 = req1_valid;
      end
      req0_ready = (state == IDLE) && req0_valid && !win1;
      req1_ready = (state == IDLE) && req1_valid && win1;
      take       = req0_ready || req1_ready;
   end

   assign busy = (state != IDLE);

   // alu_en and the response pulses are registered, so they are set on the
   // transition into ISSUE/RESP and cleared by default on every other edge.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state       <= IDLE;
         last_grant  <= 1'b1;
         grant       <= 1'b0;
         wait_cnt    <= 8'd0;
         alu_a       <= '0;
         alu_b       <= '0;
         alu_fun     <= '0;
         alu_en      <= 1'b0;
         resp0_valid <= 1'b0;
         resp1_valid <= 1'b0;
         resp_err    <= 1'b0;
         resp_data   <= '0;
      end else begin
         alu_en      <= 1'b0;
         resp0_valid <= 1'b0;
         resp1_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (take) begin
                  alu_a      <= win1 ? req1_a : req0_a;
                  alu_b      <= win1 ? req1_b : req0_b;
                  alu_fun    <= win1 ? req1_fun : req0_fun;
                  grant      <= win1;
                  last_grant <= win1;
                  alu_en     <= 1'b1;
                  state      <= ISSUE;
               end
            end
            ISSUE: begin
               wait_cnt <= 8'd0;
               state    <= WAIT;
            end
            WAIT: begin
               // A valid flag in the final WAIT cycle beats the timeout.
               if (alu_out_valid) begin
                  resp_data   <= alu_out;
                  resp_err    <= 1'b0;
                  resp0_valid <= !grant;
                  resp1_valid <= grant;
                  state       <= RESP;
               end else if (wait_cnt == TIMEOUT_LAST) begin
                  resp_data   <= '0;
                  resp_err    <= 1'b1;
                  resp0_valid <= !grant;
                  resp1_valid <= grant;
                  state       <= RESP;
               end else begin
                  wait_cnt <= wait_cnt + 8'd1;
               end
            end
            RESP: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/alu_req_arbiter.md
Name: alu_req_arbiter

Overview:
- Shares one ALU between two requesters (req0 = system controller command path, req1 = secondary/debug path).
- Accepts one operation at a time with a valid/ready handshake and arbitrates round-robin.
- Drives the ALU enable, function and operands, then waits for the ALU's registered valid flag, with a timeout.
- Returns the result to the granted requester as a one-cycle response pulse. Sits between the requesters and the ALU top.

Parameters:
- OP_WIDTH, 8, width of operands A/B.
- OUT_WIDTH, 16, width of the ALU result.
- FUN_WIDTH, 4, width of the ALU function code.
- TIMEOUT, 8, maximum WAIT cycles before an error response; legal range 2..255.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  asynchronous reset, active-low.
- req0_valid  in  1  requester 0 has an op.
- req0_ready  out  1  requester 0 op accepted this cycle (when valid).
- req0_a, req0_b  in  OP_WIDTH  requester 0 operands.
- req0_fun  in  FUN_WIDTH  requester 0 function.
- req1_valid, req1_ready, req1_a, req1_b, req1_fun: same as requester 0, for requester 1.
- resp0_valid  out  1  one-cycle response pulse to requester 0.
- resp1_valid  out  1  one-cycle response pulse to requester 1.
- resp_err  out  1  response is a timeout; qualified by respN_valid.
- resp_data  out  OUT_WIDTH  result; qualified by respN_valid.
- alu_a, alu_b  out  OP_WIDTH  operands to the ALU.
- alu_fun  out  FUN_WIDTH  function to the ALU.
- alu_en  out  1  ALU enable.
- alu_out  in  OUT_WIDTH  ALU registered result.
- alu_out_valid  in  1  ALU registered valid flag.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (async, RST low): state=IDLE; last_grant=1 (req0 wins first); all registered outputs 0 (alu_a/b/fun, alu_en, resp0/1_valid, resp_err, resp_data); timeout counter 0.
- Reset mid-operation aborts the operation with no response; the requester re-issues.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Winner = the only valid requester. If both are valid, winner = the requester other than last_grant.
  - reqN_ready is combinational: high only in IDLE, only for the winner, only while reqN_valid=1. The loser's ready stays 0.
  - On handshake: latch reqN_a/b/fun into alu_a/b/fun, record the grant, last_grant<=N, go to ISSUE.
- ISSUE: alu_en=1 for exactly this one cycle; clear the counter; go to WAIT.
- WAIT:
  - alu_en=0; operands held stable.
  - If alu_out_valid=1: resp_data<=alu_out, resp_err<=0, go to RESP.
  - Otherwise increment the counter. When the counter reaches TIMEOUT: resp_data<=0, resp_err<=1, go to RESP.
  - Valid and timeout in the same cycle: valid wins.
- RESP: the granted respN_valid=1 for exactly one cycle. resp_data and resp_err hold until the next RESP. Go to IDLE. No ready in RESP.
- Nominal latency, measured from the handshake cycle (cycle 0): alu_en high in cycle 1, alu_out_valid in cycle 2, resp pulse in cycle 3, next accept in cycle 4. Peak throughput is 1 op per 4 cycles.
- There is no response backpressure; requesters must sample respN_valid when it pulses.
- alu_out_valid arriving outside WAIT is ignored. Requester inputs that change after the handshake have no effect on the operation in flight.
- resp0_valid and resp1_valid are never high together. busy = (state != IDLE).

Test Plan:
- Reset, then req0 a=8'h0F b=8'h33 fun=4'h4 with the ALU model returning 16'h0003 one cycle after en: req0_ready in cycle 0, alu_en in cycle 1 only, resp0_valid in cycle 3 with resp_data=16'h0003, resp_err=0.
- req0 and req1 held valid continuously, ALU echoing {a,b}: grants alternate 0,1,0,1; resp0/resp1 pulses alternate at a 4-cycle spacing; the loser's ready stays 0 while it waits.
- ALU model never asserts valid, TIMEOUT=8: resp1_valid=1, resp_err=1, resp_data=0 exactly 8 WAIT cycles after ISSUE; back to IDLE.
- alu_out_valid on the same cycle the counter hits TIMEOUT: resp_err=0 and resp_data = ALU value. A spurious alu_out_valid in IDLE produces no response.
- RST low during WAIT: outputs go to 0 asynchronously and no respN_valid is issued. After release, req0 wins against a simultaneous req1.
- req0 changes a/b on the cycle after the handshake: alu_a/alu_b keep the original values through WAIT.
